my_bullet_control: RTL and testbench
====================================

// Module: my_bullet_control
// PURPOSE
//   Player bullet manager downstream of the player-plane position controller. Consumes the
//   plane centre (my_plane_x/y), the fire key and the frame strobe vs_neg. Spawns bullets at
//   the plane nose, moves them up once per frame and retires them at the screen top or on kill.
//   Answers per-pixel queries from the VGA renderer and exposes slot state to collision logic.
// PARAMETERS
//   N_BULLETS        8      number of bullet slots (2..16)
//   BULLET_HALF_W    11'd4  half width of bullet box, pixels
//   BULLET_HALF_H    11'd8  half height of bullet box, pixels
//   PLANE_HALF_H     11'd64 half height of player plane; spawn offset
//   SPEED            11'd6  upward move per frame, pixels
//   COOLDOWN         6'd10  minimum frames between two spawns
// PORTS
//   clk            in   1        system clock
//   rst            in   1        async reset, active high
//   vs_neg         in   1        one-cycle strobe at vsync falling edge (frame tick)
//   fire           in   1        fire key level, already synchronised, high = pressed
//   my_plane_x     in   11       plane centre x, active-area coordinates
//   my_plane_y     in   11       plane centre y
//   pix_x          in   11       renderer query x
//   pix_y          in   11       renderer query y
//   kill_valid     in   1        collision logic retires a slot this cycle
//   kill_idx       in   4        slot to retire (ignored if >= N_BULLETS)
//   bullet_pixel   out  1        query hit, registered, 1-cycle latency
//   bullet_active  out  N        per-slot active flags
//   bullet_count   out  5        number of active slots
//   busy           out  1        frame update FSM not in IDLE
// BEHAVIOUR
//   Reset: all slots inactive, slot x/y = 0, cooldown = 0, fire_pend = 0, state IDLE;
//     bullet_pixel, bullet_active, bullet_count, busy all 0. Reset mid-update aborts cleanly.
//   Fire request: fire_pend set on any cycle fire==1 and cooldown==0; cleared only by spawn.
//   FSM IDLE -> UPDATE on vs_neg (cycle 0). vs_neg while busy is ignored (frame dropped).
//   UPDATE: one slot per cycle, idx 0..N-1 (N cycles). Active slot: if y < SPEED+BULLET_H_TOP
//     where BULLET_H_TOP = BULLET_HALF_H, slot goes inactive; else y <= y - SPEED. x unchanged.
//   After idx N-1 -> SPAWN (1 cycle) -> IDLE. busy high in UPDATE and SPAWN.
//   SPAWN: cooldown decremented first if nonzero (saturates at 0). If fire_pend and a free
//     slot exists: lowest-index free slot gets x = my_plane_x,
//     y = my_plane_y - PLANE_HALF_H - BULLET_HALF_H (if my_plane_y < PLANE_HALF_H+BULLET_HALF_H
//     no spawn); set active, clear fire_pend, cooldown <= COOLDOWN.
//     No free slot: fire_pend stays set, retried next frame. Plane coords sampled in SPAWN.
//   Kill: kill_valid clears active[kill_idx] in that cycle, any state. Kill and UPDATE or
//     SPAWN on the same slot in the same cycle: kill wins (slot ends inactive).
//   Pixel query: bullet_pixel(t+1) = OR over active slots of |pix_x-x| < BULLET_HALF_W and
//     |pix_y-y| < BULLET_HALF_H, evaluated on state at t; differences in 12-bit signed,
//     no wrap-around. Query valid in every state, including mid-update.
//   bullet_active: registered slot flags; bullet_count: registered popcount, tracks flags
//     with 1-cycle lag.
//   All arithmetic 11-bit unsigned for stored coords; y never underflows (checked before sub).
// TESTING
//   Reset, fire=1, plane (400,512), one vs_neg -> slot0 active at (400,440), count=1 after
//     N+2 cycles, busy high for exactly N+1 cycles.
//   Hold fire 30 frames -> spawns on frames 1,11,21 only (COOLDOWN=10); slots 0,1,2.
//   Bullet at y=10, vs_neg -> slot retired (10 < 14); bullet at y=14 -> y=8, stays active.
//   All 8 slots active, fire pressed -> no spawn, fire_pend held; kill slot3, next frame ->
//     new bullet in slot3.
//   kill_valid idx2 on the UPDATE cycle of slot2 -> slot2 inactive, count drops by 1.
//   Query pix (400,440) and (404,440) vs bullet at (400,440) -> 1 then 0, each 1 cycle late;
//     assert rst mid-UPDATE -> all outputs 0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/my_bullet_control.sv
// Player bullet manager: spawns bullets at the plane nose, moves them up once per frame,
// retires them at the screen top or on kill, and answers renderer pixel queries.
module my_bullet_control #(
   parameter int unsigned N_BULLETS     = 8,
   parameter logic [10:0] BULLET_HALF_W = 11'd4,
   parameter logic [10:0] BULLET_HALF_H = 11'd8,
   parameter logic [10:0] PLANE_HALF_H  = 11'd64,
   parameter logic [10:0] SPEED         = 11'd6,
   parameter logic [5:0]  COOLDOWN      = 6'd10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vs_neg,
   input  logic                 fire,
   input  logic [10:0]          my_plane_x,
   input  logic [10:0]          my_plane_y,
   input  logic [10:0]          pix_x,
   input  logic [10:0]          pix_y,
   input  logic                 kill_valid,
   input  logic [3:0]           kill_idx,
   output logic                 bullet_pixel,
   output logic [N_BULLETS-1:0] bullet_active,
   output logic [4:0]           bullet_count,
   output logic                 busy
);

   localparam logic [10:0] RETIRE_LIM = SPEED + BULLET_HALF_H;
   localparam logic [10:0] SPAWN_OFS  = PLANE_HALF_H + BULLET_HALF_H;
   localparam logic [3:0]  LAST_IDX   = 4'(N_BULLETS - 1);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_SPAWN} state_t;

   state_t               state, state_nxt;
   logic [3:0]           idx, idx_nxt;
   logic [10:0]          bx [N_BULLETS];
   logic [10:0]          by [N_BULLETS];
   logic [N_BULLETS-1:0] active;
   logic [5:0]           cooldown;
   logic                 fire_pend;

   logic [5:0]           cd_dec;
   logic                 pend_eff;
   logic                 free_found;
   logic [3:0]           free_idx;
   logic                 spawn_ok;
   logic [10:0]          spawn_y;
   logic                 hit_c;
   logic [4:0]           cnt_c;
   logic signed [11:0]   dx, dy;
   logic [11:0]          ax, ay;

   assign bullet_active = active;
   assign busy          = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (vs_neg) begin
               state_nxt = S_UPDATE;
               idx_nxt   = '0;
            end
         end
         S_UPDATE: begin
            if (idx == LAST_IDX) begin
               state_nxt = S_SPAWN;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + 4'd1;
            end
         end
         S_SPAWN: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A fire request held through the frame where cooldown expires counts in that same frame.
   always_comb begin
      cd_dec     = (cooldown != '0) ? cooldown - 6'd1 : '0;
      pend_eff   = fire_pend | (fire & (cd_dec == '0));
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < N_BULLETS; i++) begin
         if (!active[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = 4'(i);
         end
      end
      spawn_y  = my_plane_y - SPAWN_OFS;
      spawn_ok = (state == S_SPAWN) && pend_eff && free_found && (my_plane_y >= SPAWN_OFS);
   end

   always_comb begin
      hit_c = 1'b0;
      cnt_c = '0;
      dx    = '0;
      dy    = '0;
      ax    = '0;
      ay    = '0;
      for (int unsigned i = 0; i < N_BULLETS; i++) begin
         dx = $signed({1'b0, pix_x}) - $signed({1'b0, bx[i]});
         dy = $signed({1'b0, pix_y}) - $signed({1'b0, by[i]});
         ax = dx[11] ? 12'(-dx) : 12'(dx);
         ay = dy[11] ? 12'(-dy) : 12'(dy);
         if (active[i] && (ax < {1'b0, BULLET_HALF_W}) && (ay < {1'b0, BULLET_HALF_H}))
            hit_c = 1'b1;
         cnt_c = cnt_c + 5'(active[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         active       <= '0;
         cooldown     <= '0;
         fire_pend    <= 1'b0;
         bullet_pixel <= 1'b0;
         bullet_count <= '0;
         for (int unsigned i = 0; i < N_BULLETS; i++) begin
            bx[i] <= '0;
            by[i] <= '0;
         end
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         bullet_pixel <= hit_c;
         bullet_count <= cnt_c;

         if (state == S_SPAWN)
            cooldown <= spawn_ok ? COOLDOWN : cd_dec;

         if (spawn_ok)
            fire_pend <= 1'b0;
         else if (fire && (cooldown == '0))
            fire_pend <= 1'b1;

         // Later assignments override earlier ones, so kill beats update and spawn.
         for (int unsigned i = 0; i < N_BULLETS; i++) begin
            if ((state == S_UPDATE) && (idx == 4'(i)) && active[i]) begin
               if (by[i] < RETIRE_LIM)
                  active[i] <= 1'b0;
               else
                  by[i] <= by[i] - SPEED;
            end
            if (spawn_ok && (free_idx == 4'(i))) begin
               bx[i]     <= my_plane_x;
               by[i]     <= spawn_y;
               active[i] <= 1'b1;
            end
            if (kill_valid && (kill_idx == 4'(i)))
               active[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_my_bullet_control.sv
// Scoreboard bench for my_bullet_control: expectations queued at stimulus, popped at DUT output.
module tb_my_bullet_control;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vs_neg = 1'b0;
   logic          fire = 1'b0;
   logic [10:0]   my_plane_x = '0;
   logic [10:0]   my_plane_y = '0;
   logic [10:0]   pix_x = '0;
   logic [10:0]   pix_y = '0;
   logic          kill_valid = 1'b0;
   logic [3:0]    kill_idx = '0;
   logic          bullet_pixel;
   logic [N-1:0]  bullet_active;
   logic [4:0]    bullet_count;
   logic          busy;

   int    n_checks = 0;
   int    n_fail   = 0;
   string tag_q[$];
   int    exp_q[$];

   my_bullet_control #(.N_BULLETS(N)) dut (
      .clk(clk), .rst(rst), .vs_neg(vs_neg), .fire(fire),
      .my_plane_x(my_plane_x), .my_plane_y(my_plane_y),
      .pix_x(pix_x), .pix_y(pix_y),
      .kill_valid(kill_valid), .kill_idx(kill_idx),
      .bullet_pixel(bullet_pixel), .bullet_active(bullet_active),
      .bullet_count(bullet_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic expect_v(input string tag, input int exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic observe(input int got);
      if (tag_q.size() == 0) begin
         check_val("sb_underflow", 0, 1);
      end else begin
         check_val(tag_q.pop_front(), got, exp_q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; vs_neg = 1'b0; fire = 1'b0; kill_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // One frame: strobe, then N+2 cycles so the popcount has caught up.
   task automatic frame(output int busy_cyc, output int cnt_spawn, output int act_spawn);
      vs_neg = 1'b1;
      tick();
      vs_neg = 1'b0;
      busy_cyc = 0; cnt_spawn = 0; act_spawn = 0;
      for (int j = 0; j < N + 2; j++) begin
         if (busy) busy_cyc++;
         if (j == N + 1) begin
            cnt_spawn = int'(bullet_count);
            act_spawn = int'(bullet_active);
         end
         tick();
      end
   endtask

   task automatic query(input int x, input int y, input int exp);
      pix_x = 11'(x); pix_y = 11'(y);
      expect_v($sformatf("pix(%0d,%0d)", x, y), exp);
      tick();
      observe(int'(bullet_pixel));
   endtask

   int bc, cs, as_;

   initial begin
      do_reset();
      expect_v("rst_pixel", 0);  observe(int'(bullet_pixel));
      expect_v("rst_active", 0); observe(int'(bullet_active));
      expect_v("rst_count", 0);  observe(int'(bullet_count));
      expect_v("rst_busy", 0);   observe(int'(busy));

      // First spawn from the plane nose
      fire = 1'b1; my_plane_x = 11'd400; my_plane_y = 11'd512;
      tick();
      expect_v("f1_busy_cycles", N + 1);
      expect_v("f1_count_lag", 0);
      expect_v("f1_active_at_spawn", 1);
      expect_v("f1_count", 1);
      frame(bc, cs, as_);
      fire = 1'b0;
      observe(bc); observe(cs); observe(as_); observe(int'(bullet_count));
      query(404, 440, 0);
      pix_x = 11'd400; pix_y = 11'd440;
      expect_v("pix_latency", 0);
      #2 observe(int'(bullet_pixel));
      tick();
      expect_v("pix_hit_late", 1);
      observe(int'(bullet_pixel));
      query(403, 447, 1);
      query(400, 448, 0);
      query(396, 440, 0);

      // Cooldown: fire held 30 frames
      do_reset();
      fire = 1'b1; my_plane_x = 11'd400; my_plane_y = 11'd1000;
      for (int f = 1; f <= 30; f++) begin
         expect_v($sformatf("cd_count_f%0d", f), (f >= 21) ? 3 : (f >= 11) ? 2 : 1);
         frame(bc, cs, as_);
         observe(int'(bullet_count));
      end
      expect_v("cd_active", 7);
      observe(int'(bullet_active));

      // Retire at top: y=10 retires, y=14 moves to 8
      do_reset();
      fire = 1'b1; my_plane_x = 11'd400; my_plane_y = 11'd82;
      frame(bc, cs, as_);
      fire = 1'b0;
      query(400, 10, 1);
      expect_v("retire_count", 0);
      frame(bc, cs, as_);
      observe(int'(bullet_count));
      do_reset();
      fire = 1'b1; my_plane_y = 11'd86;
      frame(bc, cs, as_);
      fire = 1'b0;
      expect_v("edge14_count", 1);
      frame(bc, cs, as_);
      observe(int'(bullet_count));
      query(400, 1, 1);
      query(400, 16, 0);

      // Spawn boundary on plane y
      do_reset();
      fire = 1'b1; my_plane_y = 11'd71;
      expect_v("low_plane_nospawn", 0);
      frame(bc, cs, as_);
      observe(int'(bullet_count));
      my_plane_y = 11'd72;
      expect_v("plane72_spawn", 1);
      frame(bc, cs, as_);
      observe(int'(bullet_count));
      query(400, 0, 1);

      // Fill all slots, then hold fire with no free slot
      do_reset();
      fire = 1'b1; my_plane_x = 11'd400; my_plane_y = 11'd2000;
      for (int f = 1; f <= 82; f++) frame(bc, cs, as_);
      expect_v("full_count", 8);  observe(int'(bullet_count));
      expect_v("full_active", 255); observe(int'(bullet_active));
      kill_valid = 1'b1; kill_idx = 4'd9;
      tick();
      expect_v("kill_oob_ignored", 255); observe(int'(bullet_active));
      kill_idx = 4'd3;
      tick();
      kill_valid = 1'b0;
      expect_v("kill3_active", 247); observe(int'(bullet_active));
      tick();
      expect_v("kill3_count", 7); observe(int'(bullet_count));
      my_plane_x = 11'd100;
      expect_v("refill_active", 255);
      frame(bc, cs, as_);
      observe(int'(bullet_active));
      fire = 1'b0;
      query(100, 1928, 1);
      query(104, 1928, 0);

      // Kill on the UPDATE cycle of slot 2
      vs_neg = 1'b1; tick(); vs_neg = 1'b0;
      tick(); tick();
      kill_valid = 1'b1; kill_idx = 4'd2;
      tick();
      kill_valid = 1'b0;
      for (int j = 0; j < N - 1; j++) tick();
      expect_v("kill_upd_active", 251); observe(int'(bullet_active));
      expect_v("kill_upd_count", 7);    observe(int'(bullet_count));
      query(100, 1922, 1);

      // Reset mid-UPDATE
      vs_neg = 1'b1; tick(); vs_neg = 1'b0;
      tick(); tick();
      expect_v("pre_rst_busy", 1); observe(int'(busy));
      rst = 1'b1;
      #1;
      expect_v("midrst_pixel", 0);  observe(int'(bullet_pixel));
      expect_v("midrst_active", 0); observe(int'(bullet_active));
      expect_v("midrst_count", 0);  observe(int'(bullet_count));
      expect_v("midrst_busy", 0);   observe(int'(busy));
      tick();
      rst = 1'b0;
      tick(); tick();
      expect_v("post_rst_busy", 0);  observe(int'(busy));
      expect_v("post_rst_pixel", 0); observe(int'(bullet_pixel));
      expect_v("post_rst_count", 0); observe(int'(bullet_count));

      check_val("sb_leftover", tag_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
